// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl
// Run controller for the single-cycle RISC-V core. It streams a program into
// instruction memory while holding the core in reset. It then sequences
// free-run, single-step, pause and resume. Execution stops on ebreak, on
// ecall, or when the cycle budget is used up.
//
// Ports
//   clock, rst          : rising-edge clock, synchronous active-high reset
//   load_valid/ready    : program word handshake (load_data, load_last)
//   imem_we/waddr/wdata : instruction-memory write port (zero latency)
//   start, step         : run/resume and single-step requests (levels)
//   halt_req            : pause request while running
//   run_limit           : cycle budget, 0 = unlimited (sampled live)
//   core_instr          : instruction the core executes this cycle
//   core_rst, core_en   : core reset and clock-enable
//   state               : FSM state code
//   halt_cause          : 0 none, 1 ebreak, 2 ecall, 3 limit
//   done                : high in HALTED
//   load_ovf            : sticky, memory wrapped during load
//   cycle_count         : enabled core cycles (saturating)
module riscv_run_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CYC_W  = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic [CYC_W-1:0]  run_limit,
  input  logic [31:0]       core_instr,
  output logic              core_rst,
  output logic              core_en,
  output logic [2:0]        state,
  output logic [1:0]        halt_cause,
  output logic              done,
  output logic              load_ovf,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_ECALL  = 2'd2;
  localparam logic [1:0] CAUSE_LIMIT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_PAUSE  = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          w_exit_cause;
  logic [ADDR_W-1:0]   r_waddr;
  logic                r_load_ovf;
  logic [CYC_W-1:0]    r_cycle_count;
  logic [1:0]          r_halt_cause;
  logic                w_accept;
  logic [CYC_W:0]      w_cnt_plus1;
  logic [CYC_W-1:0]    w_cnt_sat;
  logic                w_limit_hit;

  assign w_accept = load_valid & load_ready;

  // One extra bit keeps the limit compare correct even at an all-ones count.
  assign w_cnt_plus1 = {1'b0, r_cycle_count} + (CYC_W+1)'(1);
  assign w_cnt_sat   = (&r_cycle_count) ? r_cycle_count : w_cnt_plus1[CYC_W-1:0];
  assign w_limit_hit = (run_limit != CYC_W'(0)) && (w_cnt_plus1 >= {1'b0, run_limit});

  // State register
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, including the prioritised exit checks of RUN/STEP
  always_comb begin
    w_next_state = r_state;
    w_exit_cause = CAUSE_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = load_last ? S_READY : S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept && load_last) begin
          w_next_state = S_READY;
        end else begin
          w_next_state = S_LOAD;
        end
      end
      S_READY, S_PAUSE: begin
        if (start) begin
          w_next_state = S_RUN;
        end else if (step) begin
          w_next_state = S_STEP;
        end else begin
          w_next_state = r_state;
        end
      end
      S_RUN, S_STEP: begin
        if (core_instr == INSTR_EBREAK) begin
          w_next_state = S_HALTED;
          w_exit_cause = CAUSE_EBREAK;
        end else if (core_instr == INSTR_ECALL) begin
          w_next_state = S_HALTED;
          w_exit_cause = CAUSE_ECALL;
        end else if (w_limit_hit) begin
          w_next_state = S_HALTED;
          w_exit_cause = CAUSE_LIMIT;
        end else if ((r_state == S_RUN) && halt_req) begin
          w_next_state = S_PAUSE;
        end else if (r_state == S_STEP) begin
          w_next_state = S_PAUSE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_HALTED: begin
        if (start) begin
          w_next_state = S_READY;
        end else begin
          w_next_state = S_HALTED;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Decoded outputs from the current state
  always_comb begin
    load_ready = 1'b0;
    core_rst   = 1'b0;
    core_en    = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        load_ready = 1'b1;
        core_rst   = 1'b1;
      end
      S_READY: begin
        core_rst = 1'b1;
      end
      S_RUN, S_STEP: begin
        core_en = 1'b1;
      end
      S_HALTED: begin
        done = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Load write address and sticky wrap flag
  always_ff @(posedge clock) begin
    if (rst) begin
      r_waddr    <= ADDR_W'(0);
      r_load_ovf <= 1'b0;
    end else if (w_accept) begin
      // The final word rewinds the pointer so READY shows address 0.
      r_waddr <= load_last ? ADDR_W'(0) : (r_waddr + ADDR_W'(1));
      if ((&r_waddr) && !load_last) begin
        r_load_ovf <= 1'b1;
      end else begin
        r_load_ovf <= r_load_ovf;
      end
    end else begin
      r_waddr    <= r_waddr;
      r_load_ovf <= r_load_ovf;
    end
  end

  // Cycle counter and halt cause; entering or sitting in READY clears both
  always_ff @(posedge clock) begin
    if (rst) begin
      r_cycle_count <= CYC_W'(0);
      r_halt_cause  <= CAUSE_NONE;
    end else if (w_next_state == S_READY) begin
      r_cycle_count <= CYC_W'(0);
      r_halt_cause  <= CAUSE_NONE;
    end else if (core_en) begin
      r_cycle_count <= w_cnt_sat;
      if (w_exit_cause != CAUSE_NONE) begin
        r_halt_cause <= w_exit_cause;
      end else begin
        r_halt_cause <= r_halt_cause;
      end
    end else begin
      r_cycle_count <= r_cycle_count;
      r_halt_cause  <= r_halt_cause;
    end
  end

  assign imem_we     = w_accept;
  assign imem_waddr  = r_waddr;
  assign imem_wdata  = load_data;
  assign state       = r_state;
  assign halt_cause  = r_halt_cause;
  assign load_ovf    = r_load_ovf;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Testbench for riscv_run_ctrl with a 4-word memory (ADDR_W=2) and a tiny
// core model (PC register reading the bench copy of instruction memory).
module tb_riscv_run_ctrl;
  localparam int ADDR_W = 2;
  localparam int CYC_W  = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic              clock;
  logic              rst;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              start;
  logic              step;
  logic              halt_req;
  logic [CYC_W-1:0]  run_limit;
  logic [31:0]       core_instr;
  logic              core_rst;
  logic              core_en;
  logic [2:0]        state;
  logic [1:0]        halt_cause;
  logic              done;
  logic              load_ovf;
  logic [CYC_W-1:0]  cycle_count;

  riscv_run_ctrl #(.ADDR_W(ADDR_W), .CYC_W(CYC_W)) dut (
    .clock(clock), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .start(start), .step(step), .halt_req(halt_req), .run_limit(run_limit),
    .core_instr(core_instr), .core_rst(core_rst), .core_en(core_en),
    .state(state), .halt_cause(halt_cause), .done(done), .load_ovf(load_ovf),
    .cycle_count(cycle_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;

  typedef struct { logic [1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [1:0] cause; logic [31:0] cnt; int en; } halt_t;
  wr_t   wr_q[$];
  halt_t halt_q[$];

  logic [31:0] mem [4];
  logic [31:0] pc;
  logic [31:0] prog [6];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: memory written by the DUT's write port, PC advanced by core_en
  always @(posedge clock) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
    if (core_rst) pc <= 32'd0;
    else if (core_en) pc <= pc + 32'd1;
  end
  assign core_instr = mem[pc[1:0]];

  // Write scoreboard and enabled-cycle counter
  always @(negedge clock) begin
    if (core_en) en_cnt++;
    if (imem_we) begin
      if (wr_q.size() == 0) begin
        check_val("wr_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check_val("wr_addr", 32'(imem_waddr), 32'(e.addr));
        check_val("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clock);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_load_ready", 32'(load_ready), 32'd1);
    check_val("rst_core_rst", 32'(core_rst), 32'd1);
    check_val("rst_core_en", 32'(core_en), 32'd0);
    check_val("rst_cycle", cycle_count, 32'd0);
    check_val("rst_ovf", 32'(load_ovf), 32'd0);
    check_val("rst_waddr", 32'(imem_waddr), 32'd0);
    rst = 1'b0;
  endtask

  task automatic load_prog(input int n, input logic exp_ovf);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == n - 1);
      wr_q.push_back('{addr: 2'(i % 4), data: prog[i]});
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clock);
    check_val("load_state", 32'(state), 32'd2);
    check_val("load_wr_left", 32'(wr_q.size()), 32'd0);
    check_val("load_ovf", 32'(load_ovf), 32'(exp_ovf));
    check_val("ready_core_rst", 32'(core_rst), 32'd1);
  endtask

  task automatic start_run();
    en_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clock);
    check_val("first_core_en", 32'(core_en), 32'd1);
    check_val("first_core_rst", 32'(core_rst), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    bit found;
    halt_t h;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clock);
      if (done) found = 1'b1;
    end
    h = halt_q.pop_front();
    if (!found) begin
      check_val("halt_timeout", 32'd0, 32'd1);
    end else begin
      check_val("halt_state", 32'(state), 32'd6);
      check_val("halt_cause", 32'(halt_cause), 32'(h.cause));
      check_val("halt_cycle", cycle_count, h.cnt);
      check_val("halt_en_cycles", 32'(en_cnt), 32'(h.en));
    end
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 6; i++) prog[i] = NOP;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = NOP;
    rst = 1'b0; load_valid = 1'b0; load_data = 32'd0; load_last = 1'b0;
    start = 1'b0; step = 1'b0; halt_req = 1'b0; run_limit = 32'd0;
    tick();
    do_reset();

    // ebreak program: 4 enabled cycles, cause 1
    fill_nops();
    prog[3] = EBREAK;
    load_prog(4, 1'b0);
    halt_q.push_back('{cause: 2'd1, cnt: 32'd4, en: 4});
    start_run();
    wait_done(20);

    // HALTED ignores everything except start
    step = 1'b1; halt_req = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    tick();
    step = 1'b0; halt_req = 1'b0; load_valid = 1'b0;
    @(negedge clock);
    check_val("halted_hold", 32'(state), 32'd6);
    check_val("halted_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clock);
    check_val("rearm_state", 32'(state), 32'd2);
    check_val("rearm_cycle", cycle_count, 32'd0);
    check_val("rearm_cause", 32'(halt_cause), 32'd0);
    check_val("rearm_core_rst", 32'(core_rst), 32'd1);

    // ecall program: halts on the 2nd instruction, cause 2
    do_reset();
    fill_nops();
    prog[1] = ECALL;
    load_prog(4, 1'b0);
    halt_q.push_back('{cause: 2'd2, cnt: 32'd2, en: 2});
    start_run();
    wait_done(20);

    // NOP program with a budget of 10
    do_reset();
    fill_nops();
    load_prog(4, 1'b0);
    run_limit = 32'd10;
    halt_q.push_back('{cause: 2'd3, cnt: 32'd10, en: 10});
    start_run();
    wait_done(30);
    run_limit = 32'd0;

    // Three single steps from READY with idle gaps
    start = 1'b1;
    tick();
    start = 1'b0;
    en_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      @(negedge clock);
      check_val("step_state", 32'(state), 32'd4);
      check_val("step_en", 32'(core_en), 32'd1);
      tick();
      @(negedge clock);
      check_val("step_pause", 32'(state), 32'd5);
      check_val("step_en_off", 32'(core_en), 32'd0);
      tick();
      tick();
    end
    check_val("step_cycle", cycle_count, 32'd3);
    check_val("step_en_cycles", 32'(en_cnt), 32'd3);

    // Pause at enabled cycle 5, then resume without core reset
    do_reset();
    fill_nops();
    load_prog(4, 1'b0);
    start_run();
    repeat (4) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    @(negedge clock);
    check_val("pause_state", 32'(state), 32'd5);
    check_val("pause_cycle", cycle_count, 32'd5);
    check_val("pause_core_rst", 32'(core_rst), 32'd0);
    check_val("pause_core_en", 32'(core_en), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clock);
    check_val("resume_state", 32'(state), 32'd3);
    check_val("resume_core_rst", 32'(core_rst), 32'd0);
    check_val("resume_pc", pc, 32'd5);

    // Reset in the middle of a run
    rst = 1'b1;
    tick();
    @(negedge clock);
    check_val("midrun_state", 32'(state), 32'd0);
    check_val("midrun_core_rst", 32'(core_rst), 32'd1);
    check_val("midrun_core_en", 32'(core_en), 32'd0);
    check_val("midrun_cycle", cycle_count, 32'd0);
    check_val("midrun_load_ready", 32'(load_ready), 32'd1);
    rst = 1'b0;

    // Lowering the limit below the count halts at the next enabled cycle
    fill_nops();
    load_prog(4, 1'b0);
    halt_q.push_back('{cause: 2'd3, cnt: 32'd6, en: 6});
    start_run();
    repeat (5) tick();
    run_limit = 32'd3;
    wait_done(20);
    run_limit = 32'd0;

    // Six-word load wraps the 4-word memory; start beats step
    do_reset();
    for (int i = 0; i < 6; i++) prog[i] = NOP + 32'(i << 20);
    load_prog(6, 1'b1);
    start = 1'b1;
    step  = 1'b1;
    tick();
    start = 1'b0;
    step  = 1'b0;
    @(negedge clock);
    check_val("start_wins", 32'(state), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
